// File: rtl/sseg_scan_ctrl.sv
// Scan and source controller for the 4-digit seven-segment display path.
// Generates the digit-multiplexing timebase with a blanking dead-time at the
// start of each slot, freezes the ALU operands at frame boundaries so the
// display never tears, and arbitrates between the ALU result and a timed
// message source.
module sseg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1000,
    parameter int MSG_HOLD  = 100
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [9:0]  a_val_i,
    input  logic        a_sign_i,
    input  logic        a_valid_i,
    input  logic        m_req_i,
    input  logic [15:0] m_val_i,
    output logic        m_ack_o,
    output logic        frame_tick_o,
    output logic [1:0]  dig_sel_o,
    output logic [3:0]  disp_en_o,
    output logic        src_o,
    output logic [9:0]  lat_val_o,
    output logic        lat_sign_o,
    output logic        lat_valid_o,
    output logic [15:0] lat_msg_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (MSG_HOLD > 0) ? $clog2(MSG_HOLD + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(MSG_HOLD);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(1);

    typedef enum logic {
        SHOW_ALU = 1'b0,
        SHOW_MSG = 1'b1
    } state_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    disp_en_q, disp_en_d;
    logic          frame_tick_q;
    logic          slot_end, frame_end;

    logic [9:0]    lat_val_q;
    logic          lat_sign_q, lat_valid_q;

    state_e        state_q;
    logic [HW-1:0] hold_q;
    logic          src_q, m_ack_q;
    logic [15:0]   lat_msg_q;

    // Next-cycle prescaler and digit, plus the enable pattern that goes with them
    always_comb begin
        slot_end  = (presc_q == PRESC_LAST);
        frame_end = slot_end && (dig_q == 2'd3);
        presc_d   = slot_end ? '0 : presc_q + 1'b1;
        dig_d     = slot_end ? dig_q + 2'd1 : dig_q;
        disp_en_d = 4'b1111;
        if (presc_d >= BLANK_END) begin
            case (dig_d)
                2'd0:    disp_en_d = 4'b1110;
                2'd1:    disp_en_d = 4'b1101;
                2'd2:    disp_en_d = 4'b1011;
                default: disp_en_d = 4'b0111;
            endcase
        end
    end

    // Scan timebase: prescaler, digit index, registered enables and frame tick
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_q      <= '0;
            dig_q        <= 2'd0;
            disp_en_q    <= 4'b1111;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            dig_q        <= dig_d;
            disp_en_q    <= disp_en_d;
            frame_tick_q <= frame_end;
        end
    end

    // ALU operands are captured only on frame boundaries so a frame never tears
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lat_val_q   <= 10'd0;
            lat_sign_q  <= 1'b0;
            lat_valid_q <= 1'b0;
        end else if (frame_end) begin
            lat_val_q   <= a_val_i;
            lat_sign_q  <= a_sign_i;
            lat_valid_q <= a_valid_i;
        end
    end

    // Source arbitration FSM; a message stays up for MSG_HOLD frames after its last acceptance
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= SHOW_ALU;
            hold_q    <= '0;
            src_q     <= 1'b0;
            m_ack_q   <= 1'b0;
            lat_msg_q <= 16'd0;
        end else begin
            m_ack_q <= 1'b0;
            if (frame_end) begin
                case (state_q)
                    SHOW_ALU: begin
                        if (m_req_i) begin
                            lat_msg_q <= m_val_i;
                            m_ack_q   <= 1'b1;
                            hold_q    <= HOLD_INIT;
                            src_q     <= 1'b1;
                            state_q   <= SHOW_MSG;
                        end else begin
                            src_q <= 1'b0;
                        end
                    end
                    default: begin
                        if (m_req_i) begin
                            lat_msg_q <= m_val_i;
                            m_ack_q   <= 1'b1;
                            hold_q    <= HOLD_INIT;
                        end else if (hold_q > HOLD_LAST) begin
                            hold_q <= hold_q - 1'b1;
                        end else begin
                            hold_q  <= '0;
                            src_q   <= 1'b0;
                            state_q <= SHOW_ALU;
                        end
                    end
                endcase
            end
        end
    end

    assign m_ack_o      = m_ack_q;
    assign frame_tick_o = frame_tick_q;
    assign dig_sel_o    = dig_q;
    assign disp_en_o    = disp_en_q;
    assign src_o        = src_q;
    assign lat_val_o    = lat_val_q;
    assign lat_sign_o   = lat_sign_q;
    assign lat_valid_o  = lat_valid_q;
    assign lat_msg_o    = lat_msg_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Testbench for sseg_scan_ctrl using SCAN_DIV=8, BLANK_CYC=2, MSG_HOLD=2.
// Expected outputs come from a cycle-count model: the number of clock edges
// since reset release determines slot, prescaler and frame position directly.
module tb_sseg_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int MSG_HOLD  = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic [9:0]  aVal = 10'd0;
    logic        aSign = 1'b0;
    logic        aValid = 1'b0;
    logic        mReq = 1'b0;
    logic [15:0] mVal = 16'd0;

    logic        mAck, frameTick, src, latSign, latValid;
    logic [1:0]  digSel;
    logic [3:0]  dispEn;
    logic [9:0]  latVal;
    logic [15:0] latMsg;

    int compared   = 0;
    int mismatched = 0;

    int          t;
    int          lastAcc;
    logic [9:0]  expVal;
    logic        expSign, expValid, expAck;
    logic [15:0] expMsg;

    sseg_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC),
        .MSG_HOLD (MSG_HOLD)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .a_val_i     (aVal),
        .a_sign_i    (aSign),
        .a_valid_i   (aValid),
        .m_req_i     (mReq),
        .m_val_i     (mVal),
        .m_ack_o     (mAck),
        .frame_tick_o(frameTick),
        .dig_sel_o   (digSel),
        .disp_en_o   (dispEn),
        .src_o       (src),
        .lat_val_o   (latVal),
        .lat_sign_o  (latSign),
        .lat_valid_o (latValid),
        .lat_msg_o   (latMsg)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic resetModel();
        t        = 0;
        lastAcc  = -1;
        expVal   = 10'd0;
        expSign  = 1'b0;
        expValid = 1'b0;
        expAck   = 1'b0;
        expMsg   = 16'd0;
    endtask

    task automatic applyStimulus(input logic [9:0] v, input logic s, input logic vld,
                                 input logic req, input logic [15:0] msg);
        aVal   = v;
        aSign  = s;
        aValid = vld;
        mReq   = req;
        mVal   = msg;
    endtask

    // Compare every output with what the cycle count since release implies
    task automatic checkOutput();
        int          presc;
        int          slot;
        logic [3:0]  expEn;
        logic        expSrc;
        presc  = t % SCAN_DIV;
        slot   = (t / SCAN_DIV) % 4;
        expEn  = (presc < BLANK_CYC) ? 4'b1111 : ~(4'b0001 << slot);
        expSrc = (lastAcc >= 0) && ((t - lastAcc) < MSG_HOLD * FRAME);
        check("dispEn",    dispEn,    expEn);
        check("digSel",    digSel,    slot);
        check("frameTick", frameTick, (t > 0) && (t % FRAME == 0));
        check("mAck",      mAck,      expAck);
        check("src",       src,       expSrc);
        check("latVal",    latVal,    expVal);
        check("latSign",   latSign,   expSign);
        check("latValid",  latValid,  expValid);
        check("latMsg",    latMsg,    expMsg);
        check("oneEnLow",  ($countones(~dispEn) <= 1), 1'b1);
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then check
    task automatic tick();
        @(posedge clk);
        expAck = 1'b0;
        if (t % FRAME == FRAME - 1) begin
            expVal   = aVal;
            expSign  = aSign;
            expValid = aValid;
            if (mReq) begin
                expMsg  = mVal;
                expAck  = 1'b1;
                lastAcc = t + 1;
            end
        end
        t++;
        #1;
        checkOutput();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic runUntil(input int phase);
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != phase; i++) tick();
    endtask

    task automatic randomA();
        aVal   = 10'($urandom);
        aSign  = 1'($urandom);
        aValid = 1'($urandom);
    endtask

    initial begin
        resetModel();

        // Reset asserted before any clock edge: outputs take reset values at once
        #1 rstN = 1'b0;
        #2 checkOutput();
        repeat (2) @(posedge clk);
        @(negedge clk) rstN = 1'b1;

        // Free-running scan with random ALU values and no message
        $display("[TB] scan timing");
        for (int i = 0; i < 2 * FRAME; i++) begin
            randomA();
            tick();
        end

        // Tear-free latch: a mid-frame change waits for the boundary
        $display("[TB] tear-free latch");
        runUntil(16);
        applyStimulus(10'd123, 1'b0, 1'b1, 1'b0, 16'h0000);
        runUntil(0);
        check("latch123", latVal, 10'd123);
        runUntil(16);
        applyStimulus(10'd456, 1'b1, 1'b1, 1'b0, 16'h0000);
        runUntil(FRAME - 1);
        check("latchHeld", latVal, 10'd123);
        tick();
        check("latch456", latVal, 10'd456);
        check("latchTick", frameTick, 1'b1);

        // Message accepted from SHOW_ALU, then times out after two frames
        $display("[TB] message");
        runUntil(16);
        applyStimulus(10'd456, 1'b1, 1'b1, 1'b1, 16'hE1E0);
        runUntil(0);
        mReq = 1'b0;
        check("msgAck", mAck, 1'b1);
        check("msgLatched", latMsg, 16'hE1E0);
        check("msgSrcOn", src, 1'b1);
        tick();
        check("msgAckOnce", mAck, 1'b0);
        runCycles(MSG_HOLD * FRAME - 2);
        check("msgSrcHeld", src, 1'b1);
        tick();
        check("msgSrcOff", src, 1'b0);

        // Re-request during SHOW_MSG restarts the hold from the new boundary
        $display("[TB] re-request");
        runUntil(24);
        applyStimulus(10'd456, 1'b1, 1'b1, 1'b1, 16'h1234);
        runUntil(0);
        mReq = 1'b0;
        runUntil(24);
        applyStimulus(10'd456, 1'b1, 1'b1, 1'b1, 16'($urandom));
        runUntil(0);
        mReq = 1'b0;
        check("reAck", mAck, 1'b1);
        runCycles(MSG_HOLD * FRAME - 1);
        check("reSrcHeld", src, 1'b1);
        tick();
        check("reSrcOff", src, 1'b0);

        // Valid drop and message request on the same boundary
        $display("[TB] simultaneous");
        runUntil(8);
        applyStimulus(10'd77, 1'b0, 1'b1, 1'b0, 16'h0000);
        runUntil(0);
        check("simValidHi", latValid, 1'b1);
        runUntil(16);
        applyStimulus(10'd78, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        runUntil(0);
        mReq = 1'b0;
        check("simValidLo", latValid, 1'b0);
        check("simSrc", src, 1'b1);

        // Randomized traffic on every input
        $display("[TB] random traffic");
        for (int i = 0; i < 10 * FRAME; i++) begin
            randomA();
            mReq = ($urandom_range(0, 3) == 0);
            mVal = 16'($urandom);
            tick();
        end
        mReq = 1'b0;

        // Asynchronous reset at prescaler 5 of slot 2 while a message is shown
        $display("[TB] async reset");
        runUntil(24);
        mReq = 1'b1;
        mVal = 16'hCAFE;
        runUntil(0);
        mReq = 1'b0;
        runUntil(2 * SCAN_DIV + 5);
        check("preRstSrc", src, 1'b1);
        #2 rstN = 1'b0;
        resetModel();
        #1 checkOutput();
        repeat (2) @(posedge clk);
        #1 checkOutput();
        @(negedge clk) rstN = 1'b1;
        runCycles(FRAME - 1);
        check("noEarlyTick", frameTick, 1'b0);
        tick();
        check("firstTick", frameTick, 1'b1);
        runCycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Scan and source controller for the 4-digit seven-segment display path. It generates the digit-multiplexing timebase, including a blanking dead-time at the start of each digit slot to suppress ghosting. It freezes the display operands at frame boundaries so the display never tears, and it arbitrates between the ALU result (default source) and a timed message source. Its outputs drive the downstream BCD/segment decoder: latched operands, digit index, active-low digit enables and source select.

Parameters:
SCAN_DIV, 50000, CLK cycles per digit slot; legal range >= 4.
BLANK_CYC, 1000, cycles at the start of each slot with all digits off; legal range 0 <= BLANK_CYC < SCAN_DIV.
MSG_HOLD, 100, number of whole frames a message is shown after its last acceptance; legal range >= 1.

Ports:
CLK  in  1  system clock, single clock domain.
RST_N  in  1  asynchronous, active-low reset.
A_VAL  in  10  ALU magnitude, binary.
A_SIGN  in  1  ALU sign; 1 = negative.
A_VALID  in  1  ALU value valid; 0 = show dashes downstream.
M_REQ  in  1  message request, level-sensitive, sampled only at frame boundaries.
M_VAL  in  16  message, four 4-bit glyph codes; [15:12] = digit 0 (left-most).
M_ACK  out  1  one-cycle pulse: message accepted.
FRAME_TICK  out  1  one-cycle pulse at each frame boundary.
DIG_SEL  out  2  current digit slot, 0 = left-most.
DISP_EN  out  4  active-low digit enables; bit 0 = digit 0.
SRC  out  1  0 = ALU operands, 1 = message operands.
LAT_VAL  out  10  frame-latched A_VAL.
LAT_SIGN  out  1  frame-latched A_SIGN.
LAT_VALID  out  1  frame-latched A_VALID.
LAT_MSG  out  16  latched M_VAL.

Behaviour:
- Reset (async, RST_N=0), all immediate: prescaler=0, DIG_SEL=0, DISP_EN=4'b1111, SRC=0, state=SHOW_ALU, hold_cnt=0, LAT_VAL=0, LAT_SIGN=0, LAT_VALID=0 (dashes), LAT_MSG=0, M_ACK=0, FRAME_TICK=0.
- Prescaler: width $clog2(SCAN_DIV); counts 0..SCAN_DIV-1 and wraps to 0. Slot end = prescaler==SCAN_DIV-1. At slot end, DIG_SEL increments mod 4 (3 wraps to 0).
- DISP_EN is registered and derived from next-cycle prescaler/DIG_SEL:
  - prescaler < BLANK_CYC: 4'b1111.
  - otherwise, per DIG_SEL: 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
  - Never more than one bit low; BLANK_CYC=0 means no blanking.
- Frame boundary = slot end while DIG_SEL==3; one frame = 4*SCAN_DIV cycles.
  - FRAME_TICK is high for the cycle after the boundary edge, i.e. aligned with DIG_SEL=0, prescaler=0.
- ALU latch: LAT_VAL, LAT_SIGN and LAT_VALID capture the A_* inputs on every frame-boundary edge, in both states. They never change at any other time.
- FSM, evaluated only on frame-boundary edges:
  - SHOW_ALU, M_REQ=1: capture LAT_MSG<=M_VAL; pulse M_ACK; hold_cnt<=MSG_HOLD; SRC<=1; go to SHOW_MSG.
  - SHOW_ALU, M_REQ=0: stay; SRC=0.
  - SHOW_MSG, M_REQ=1: recapture LAT_MSG; pulse M_ACK; hold_cnt<=MSG_HOLD (restart); stay.
  - SHOW_MSG, M_REQ=0, hold_cnt==1: SRC<=0; go to SHOW_ALU.
  - SHOW_MSG, M_REQ=0, hold_cnt>1: hold_cnt decrements.
  - Result: SRC=1 for exactly MSG_HOLD frames after the last acceptance.
- M_ACK: high exactly one cycle, coincident with FRAME_TICK. M_REQ may stay high continuously; each frame boundary with M_REQ=1 re-accepts.
- Simultaneous events: an A_* change and M_REQ at the same boundary both latch on that edge.
- Reset mid-frame: the frame is abandoned; the next frame starts at slot 0 after release, with no FRAME_TICK for the partial frame.
- All outputs change only on a CLK edge or on reset assertion.

Test Plan:
Use SCAN_DIV=8, BLANK_CYC=2, MSG_HOLD=2 throughout.
1. Scan timing: free-run after reset -> in each slot DISP_EN=1111 for prescaler 0-1, then 1110/1101/1011/0111 for prescaler 2-7 of slots 0/1/2/3; FRAME_TICK period 32 cycles; never more than one enable bit low.
2. Tear-free latch: A_VAL=123 latched, then A_VAL=456 mid-frame -> LAT_VAL stays 123 until the boundary edge, then becomes 456 alongside FRAME_TICK.
3. Message: M_REQ=1, M_VAL=16'hE1E0 in SHOW_ALU -> at the next boundary M_ACK=1 for one cycle, LAT_MSG=E1E0, SRC=1; with M_REQ=0 afterwards, SRC returns to 0 exactly 2 frames (64 cycles) later.
4. Re-request: M_REQ pulsed across the second boundary during SHOW_MSG -> second M_ACK; SRC stays 1 for 2 frames counted from that boundary.
5. Simultaneous: A_VALID 1->0 and M_REQ=1 presented at the same boundary -> LAT_VALID=0 and SRC=1 on the same edge.
6. Async reset: RST_N low at prescaler 5, slot 2, SRC=1 -> without waiting for a clock, DISP_EN=1111, SRC=0, LAT_* = 0; after release, DIG_SEL=0 and the first FRAME_TICK arrives 32 cycles later.
